clk_div_bank: RTL and testbench
===============================

Name: clk_div_bank

Overview:
- Multi-channel programmable toggle/divider bank; each channel counts clk cycles up to a per-channel compare value.
- On match, a channel toggles its output and pulses a tick.
- Per channel, the block either auto-reloads (free-running divider) or holds until re-armed by restart (one-shot).
- Sits between the control register file and the ice40 clock and strobe consumers (sample strobes, LED and test clocks).

Parameters:
WIDTH, 8, counter and compare width per channel (>=2)
CHANNELS, 4, number of independent channels (>=1)

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
en  input  CHANNELS  per-channel count enable; 0 freezes the channel
value  input  CHANNELS*WIDTH  compare values; channel i at bits [i*WIDTH +: WIDTH]
mode  input  CHANNELS  0 = one-shot (hold after match), 1 = auto-reload
restart  input  CHANNELS  synchronous re-arm/clear, level-sampled each cycle
out  output  CHANNELS  toggle outputs, registered
tick  output  CHANNELS  one-cycle pulse on match, registered, same edge as out toggle
holding  output  CHANNELS  1 while the channel is in HOLD

Behaviour:
- Reset (rst_n=0, async): cnt=0, state=COUNT, out=0, tick=0, holding=0 for all channels. Deassertion takes effect on the next posedge.
- Channels are fully independent. Per-channel rules follow; highest listed priority wins.
- State COUNT:
  - restart=1 and cnt==value (en ignored): tick=1, out toggles, cnt<=0, stay COUNT.
  - restart=1 and cnt!=value: cnt<=0, no toggle, no tick, stay COUNT (applies even if en=0).
  - en=0: cnt, out, state frozen; tick=0.
  - en=1, cnt==value, mode=1: tick=1, out toggles, cnt<=0, stay COUNT.
  - en=1, cnt==value, mode=0: tick=1, out toggles, cnt held, go HOLD.
  - en=1, cnt!=value: cnt<=cnt+1 modulo 2^WIDTH; tick=0.
- State HOLD:
  - cnt and out held; tick=0; holding=1.
  - restart=1: cnt<=0, go COUNT, no toggle, no tick.
  - en and mode are ignored in HOLD. A mode change to 1 does not leave HOLD; only restart does.
- Timing:
  - Auto-reload with en=1 gives value+1 cycles between toggles. Output period is 2*(value+1), 50% duty.
  - value=0 toggles every cycle.
  - value=2^WIDTH-1 gives the maximum period 2^(WIDTH+1).
- Compare is equality against the live value input; there is no shadow register.
  - If value is lowered below cnt mid-count, cnt keeps incrementing, wraps through 2^WIDTH-1 -> 0, and matches on the next pass. No early match.
  - mode is sampled only at the match cycle.
- Latency: tick and out change on the posedge where cnt==value is evaluated. holding rises on the same edge for mode=0.
- tick never stays high for two consecutive cycles, except in auto-reload with value=0 (tick constantly 1).
- Reset mid-operation aborts immediately. There is no pending state.

Decomposition:
- Shared package clk_div_pkg holds:
  - state encoding: typedef with COUNT=1'b0, HOLD=1'b1
  - default WIDTH and CHANNELS localparams
  - mode constants MODE_ONESHOT=0, MODE_AUTO=1
- Sub-module clk_div_chan holds one channel: counter, FSM, out/tick/holding registers, parameter WIDTH.
- clk_div_bank is a generate loop over CHANNELS that slices value and instantiates clk_div_chan.

Test Plan:
- Reset: rst_n=0 asynchronously mid-count (cnt=5) -> out=0, tick=0, holding=0 immediately; after release, first tick exactly value+1 enabled cycles later.
- Auto-reload: ch0 value=3, mode=1, en=1 for 16 cycles -> out toggles every 4 cycles (period 8), tick at cycles 4, 8, 12, 16, holding=0 throughout.
- One-shot: ch1 value=2, mode=0 -> single tick at cycle 3, out=1, holding=1, cnt frozen for 10 cycles; restart pulse -> holding=0 next edge, no toggle, next tick 3 cycles later with out=0.
- Restart and enable interplay:
  - en=0 mid-count -> cnt frozen, no tick.
  - restart at cnt=1 with en=0 -> cnt=0, no toggle.
  - restart coinciding with match (value=4, cnt=4) -> tick=1, out toggles, cnt=0, stays COUNT even with mode=0.
- Value change and boundaries, WIDTH=4, CHANNELS=3:
  - value changed 10 -> 2 at cnt=6 -> wraps 15 -> 0, match at 2 after 12 cycles.
  - value=0 auto -> out toggles every cycle, tick constant 1.
  - value=15 -> period 32.
- Independence: 3 channels with values 1/2/5, mixed modes, simultaneous restart on ch2 only -> ch0/ch1 tick timing unaffected. Tick counts over 60 cycles: ch0=30, ch1=20, ch2 per the one-shot/restart schedule.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider bank.
// Holds the per-channel state encoding, default sizing and the mode constants.
package clk_div_pkg;

    // Per-channel state: counting toward the compare value, or parked after a
    // one-shot match until restart re-arms it.
    typedef logic state_t;
    localparam state_t COUNT = 1'b0;
    localparam state_t HOLD  = 1'b1;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_CHANNELS = 4;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_AUTO    = 1'b1;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, COUNT/HOLD state, registered out/tick.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          count enable (0 freezes the channel while counting)
//   value       live compare value
//   mode        0 = one-shot (park in HOLD after match), 1 = auto-reload
//   restart     synchronous re-arm / counter clear
//   out         toggle output, flips on every match
//   tick        one-cycle pulse on the edge where out flips
//   holding     1 while the channel is parked in HOLD
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] value,
    input  logic             mode,
    input  logic             restart,
    output logic             out,
    output logic             tick,
    output logic             holding
);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic             match;

    // Compare against the live value; if value drops below cnt the counter
    // simply wraps and matches on the next pass.
    assign match   = (cnt == value);
    assign holding = (state == HOLD);

    // Counter and state update. Restart outranks enable, and a restart that
    // lands on a match still produces the tick/toggle but never enters HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COUNT;
            cnt   <= '0;
            out   <= 1'b0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (state == COUNT) begin
                if (restart) begin
                    cnt <= '0;
                    if (match) begin
                        tick <= 1'b1;
                        out  <= ~out;
                    end
                end else if (en) begin
                    if (match) begin
                        tick <= 1'b1;
                        out  <= ~out;
                        if (mode == MODE_AUTO) begin
                            cnt <= '0;
                        end else begin
                            state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end else begin
                // Parked: only restart leaves HOLD, en and mode are ignored.
                if (restart) begin
                    cnt   <= '0;
                    state <= COUNT;
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable toggle/divider channels.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          per-channel count enable
//   value       compare values, channel i at [i*WIDTH +: WIDTH]
//   mode        per-channel 0 = one-shot, 1 = auto-reload
//   restart     per-channel synchronous re-arm / clear
//   out         per-channel toggle outputs
//   tick        per-channel match pulses
//   holding     per-channel HOLD indicators
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] value,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       restart,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       holding
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clk_div_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[i]),
            .value   (value[i*WIDTH +: WIDTH]),
            .mode    (mode[i]),
            .restart (restart[i]),
            .out     (out[i]),
            .tick    (tick[i]),
            .holding (holding[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank (WIDTH=4, CHANNELS=3): directed
// scenarios with fixed expectations, then randomized traffic compared every
// cycle against a per-channel reference model.
module tb_clk_div_bank;

    localparam int W  = 4;
    localparam int CH = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH-1:0]   en = '0;
    logic [CH*W-1:0] value = '0;
    logic [CH-1:0]   mode = '0;
    logic [CH-1:0]   restart = '0;
    logic [CH-1:0]   out;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   holding;

    int checks = 0;
    int errors = 0;

    // Reference model state: counter as a plain integer, hold flag, out level.
    int            m_cnt [CH];
    logic [CH-1:0] m_out, m_tick, m_hold;
    int            tick_count [CH];

    clk_div_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .value   (value),
        .mode    (mode),
        .restart (restart),
        .out     (out),
        .tick    (tick),
        .holding (holding)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check_vec({tag, "/out"}, out, m_out);
        check_vec({tag, "/tick"}, tick, m_tick);
        check_vec({tag, "/holding"}, holding, m_hold);
    endtask

    task automatic applyStimulus(input logic [CH-1:0] e, input logic [CH*W-1:0] v,
                                 input logic [CH-1:0] m, input logic [CH-1:0] r);
        en      = e;
        value   = v;
        mode    = m;
        restart = r;
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i]      = 0;
            tick_count[i] = 0;
        end
        m_out  = '0;
        m_tick = '0;
        m_hold = '0;
    endtask

    // One clock of the channel rules, evaluated from the inputs seen at the edge.
    task automatic model_step();
        for (int i = 0; i < CH; i++) begin
            int v;
            bit hit;
            v   = int'(value[i*W +: W]);
            hit = (m_cnt[i] == v);
            m_tick[i] = 1'b0;
            if (m_hold[i]) begin
                if (restart[i]) begin
                    m_cnt[i]  = 0;
                    m_hold[i] = 1'b0;
                end
            end else if (restart[i]) begin
                if (hit) begin
                    m_tick[i] = 1'b1;
                    m_out[i]  = ~m_out[i];
                end
                m_cnt[i] = 0;
            end else if (en[i]) begin
                if (hit) begin
                    m_tick[i] = 1'b1;
                    m_out[i]  = ~m_out[i];
                    if (mode[i]) m_cnt[i] = 0;
                    else         m_hold[i] = 1'b1;
                end else begin
                    m_cnt[i] = (m_cnt[i] + 1) % (1 << W);
                end
            end
        end
    endtask

    // Advance one cycle: model follows the edge, outputs compared at negedge.
    task automatic run_cycle(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int i = 0; i < CH; i++) if (tick[i] === 1'b1) tick_count[i]++;
        checkOutput(tag);
    endtask

    // Assert reset away from an edge, check outputs clear at once, release.
    task automatic do_reset(input string tag);
        applyStimulus('0, '0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput({tag, "/async"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int wait_cycles;
        int first_tick, second_tick;

        model_reset();
        @(negedge clk);
        do_reset("reset0");

        // Auto-reload ch0 value=3: tick on every fourth edge, never holding.
        applyStimulus(3'b001, {4'd0, 4'd0, 4'd3}, 3'b001, 3'b000);
        for (int c = 1; c <= 16; c++) begin
            run_cycle("auto");
            check_val("auto/tick0", int'(tick[0]), (c % 4 == 0) ? 1 : 0);
            check_val("auto/out0", int'(out[0]), (c / 4) % 2);
            check_val("auto/hold0", int'(holding[0]), 0);
        end
        check_val("auto/count0", tick_count[0], 4);

        // One-shot ch1 value=2: tick on edge 3, park, restart, tick 3 later.
        do_reset("reset1");
        applyStimulus(3'b010, {4'd0, 4'd2, 4'd0}, 3'b000, 3'b000);
        for (int c = 1; c <= 3; c++) run_cycle("oneshot");
        check_val("oneshot/tick1", int'(tick[1]), 1);
        check_val("oneshot/out1", int'(out[1]), 1);
        check_val("oneshot/hold1", int'(holding[1]), 1);
        for (int c = 1; c <= 10; c++) run_cycle("oneshot/park");
        check_val("oneshot/parkhold", int'(holding[1]), 1);
        applyStimulus(3'b010, {4'd0, 4'd2, 4'd0}, 3'b000, 3'b010);
        run_cycle("oneshot/restart");
        check_val("oneshot/unpark", int'(holding[1]), 0);
        check_val("oneshot/rtick", int'(tick[1]), 0);
        applyStimulus(3'b010, {4'd0, 4'd2, 4'd0}, 3'b000, 3'b000);
        for (int c = 1; c <= 3; c++) run_cycle("oneshot/rerun");
        check_val("oneshot/tick1b", int'(tick[1]), 1);
        check_val("oneshot/out1b", int'(out[1]), 0);

        // Enable/restart interplay on ch0 value=4 one-shot.
        do_reset("reset2");
        applyStimulus(3'b001, {4'd0, 4'd0, 4'd4}, 3'b000, 3'b000);
        run_cycle("inter/count");
        applyStimulus(3'b000, {4'd0, 4'd0, 4'd4}, 3'b000, 3'b000);
        for (int c = 1; c <= 3; c++) run_cycle("inter/freeze");
        applyStimulus(3'b000, {4'd0, 4'd0, 4'd4}, 3'b000, 3'b001);
        run_cycle("inter/clear");
        check_val("inter/cleartick", int'(tick[0]), 0);
        applyStimulus(3'b001, {4'd0, 4'd0, 4'd4}, 3'b000, 3'b000);
        for (int c = 1; c <= 4; c++) run_cycle("inter/recount");
        check_val("inter/nomatch", int'(tick[0]), 0);
        applyStimulus(3'b001, {4'd0, 4'd0, 4'd4}, 3'b000, 3'b001);
        run_cycle("inter/rmatch");
        check_val("inter/rmatch_tick", int'(tick[0]), 1);
        check_val("inter/rmatch_out", int'(out[0]), 1);
        check_val("inter/rmatch_hold", int'(holding[0]), 0);

        // Async reset mid-count (cnt=5), then first tick value+1 edges later.
        do_reset("reset3");
        applyStimulus(3'b001, {4'd0, 4'd0, 4'd10}, 3'b001, 3'b000);
        for (int c = 1; c <= 5; c++) run_cycle("midreset/count");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput("midreset/async");
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            run_cycle("midreset/latency");
            if (tick[0] === 1'b1) begin
                wait_cycles = c;
                break;
            end
        end
        check_val("midreset/first_tick", wait_cycles, 11);

        // Value lowered 10 -> 2 at cnt=6: counter wraps; cnt reaches 2 after
        // 12 edges and the match fires on the 13th.
        do_reset("reset4");
        applyStimulus(3'b100, {4'd10, 4'd0, 4'd0}, 3'b100, 3'b000);
        for (int c = 1; c <= 6; c++) run_cycle("vchg/count");
        applyStimulus(3'b100, {4'd2, 4'd0, 4'd0}, 3'b100, 3'b000);
        wait_cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            run_cycle("vchg/wrap");
            if (tick[2] === 1'b1) begin
                wait_cycles = c;
                break;
            end
        end
        check_val("vchg/match_edge", wait_cycles, 13);

        // value=0 auto-reload: tick constantly high, out toggles each cycle.
        do_reset("reset5");
        applyStimulus(3'b001, {4'd0, 4'd0, 4'd0}, 3'b001, 3'b000);
        for (int c = 1; c <= 8; c++) begin
            run_cycle("v0");
            check_val("v0/tick0", int'(tick[0]), 1);
            check_val("v0/out0", int'(out[0]), c % 2);
        end

        // value=15: half period 16, full period 32.
        do_reset("reset6");
        applyStimulus(3'b100, {4'd15, 4'd0, 4'd0}, 3'b100, 3'b000);
        first_tick  = 0;
        second_tick = 0;
        for (int c = 1; c <= 64; c++) begin
            run_cycle("v15");
            if (tick[2] === 1'b1) begin
                if (first_tick == 0) first_tick = c;
                else if (second_tick == 0) second_tick = c;
            end
        end
        check_val("v15/first", first_tick, 16);
        check_val("v15/half_period", second_tick - first_tick, 16);
        check_val("v15/count", tick_count[2], 4);

        // Independence: ch0 v1 auto, ch1 v2 auto, ch2 v5 one-shot with
        // restarts on edges 20 and 40 -> ch2 ticks on 6, 26, 46.
        do_reset("reset7");
        for (int c = 1; c <= 60; c++) begin
            applyStimulus(3'b111, {4'd5, 4'd2, 4'd1}, 3'b011,
                          {(c == 20 || c == 40), 2'b00});
            run_cycle("indep");
        end
        check_val("indep/count0", tick_count[0], 30);
        check_val("indep/count1", tick_count[1], 20);
        check_val("indep/count2", tick_count[2], 3);

        // Randomized traffic against the model.
        do_reset("reset8");
        for (int c = 0; c < 500; c++) begin
            logic [CH*W-1:0] v;
            logic [CH-1:0]   r;
            v = value;
            if ($urandom_range(0, 15) == 0) v = CH*W'($urandom);
            for (int i = 0; i < CH; i++) r[i] = ($urandom_range(0, 9) == 0);
            applyStimulus(CH'($urandom) | CH'($urandom), v, CH'($urandom), r);
            run_cycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
